modn_check_framer: RTL and testbench



---
 rtl/modn_check_framer_pkg.sv | 20 ++
 rtl/modn_check_framer_if.sv | 23 ++
 rtl/modn_check_framer_step.sv | 28 ++
 rtl/modn_check_framer.sv | 156 +++++++++++++++
 tb/tb_modn_check_framer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/modn_check_framer_pkg.sv
// Shared definitions for the mod-N check framer: FSM encodings, check-width
// derivation and parameter legality.
package modn_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_DATA = 2'd1;
  localparam state_t ST_CHK  = 2'd2;

  // Smallest width that can hold every residue 0..mod-1.
  function automatic int modn_chk_w(input int mod);
    return $clog2(mod);
  endfunction

  function automatic bit modn_mod_legal(input int mod);
    return mod >= 2;
  endfunction

endpackage

// File: rtl/modn_check_framer_if.sv
// Payload handshake and serial frame bundle for the mod-N check framer.
// A word transfers on a rising clk edge where in_valid && in_ready; in_data must
// stay stable while in_valid is high and in_ready is low. ser_* has no backpressure.
interface modn_check_framer_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              ser_sof;
  logic              ser_eof;
  logic              ser_chk;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, ser_sof, ser_eof, ser_chk
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, ser_sof, ser_eof, ser_chk
  );
endinterface

// File: rtl/modn_check_framer_step.sv
// One residue step of a serial mod-N divider: r_next = (2r + b) mod MOD.
// Since r < MOD, 2r+b < 2*MOD and a single conditional subtract suffices.
module modn_step
  import modn_pkg::*;
#(
  parameter int MOD = 5,
  parameter int W   = modn_chk_w(MOD)
) (
  input  logic [W-1:0] r,
  input  logic         b,
  output logic [W-1:0] r_next
);

  localparam logic [W:0] MOD_V = MOD[W:0];

  logic [W:0] sum;
  logic [W:0] res;
  logic       res_unused;

  always_comb begin
    sum = {r, b};
    res = (sum >= MOD_V) ? (sum - MOD_V) : sum;
  end

  assign r_next     = res[W-1:0];
  assign res_unused = res[W];

endmodule

// File: rtl/modn_check_framer.sv
// Serialises DATA_W-bit payloads MSB-first and appends CHK_W check bits so the
// whole frame, read as a binary number, is divisible by MOD.
module modn_check_framer
  import modn_pkg::*;
#(
  parameter int MOD    = 5,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  modn_check_framer_if.slave  bus,
  output state_t              dbg_state
);

  localparam int CHK_W = modn_chk_w(MOD);
  localparam int SH_W  = (DATA_W > CHK_W) ? DATA_W : CHK_W;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam int DPAD  = SH_W - DATA_W;
  localparam int CPAD  = SH_W - CHK_W;

  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CHK_LAST  = CNT_W'(CHK_W - 1);
  localparam logic [CHK_W-1:0] MOD_LO    = MOD[CHK_W-1:0];

  if (!modn_mod_legal(MOD)) begin : g_bad_mod
    $error("modn_check_framer: MOD must be >= 2");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CHK_W-1:0]  r_q, r_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              chk_q, chk_d;
  logic              accept;
  logic [CHK_W-1:0]  chk_val;

  // t[0] is the residue including the bit on ser_out now; t[1..CHK_W]
  // append CHK_W zero bits, giving the residue of payload * 2^CHK_W.
  logic [CHK_W-1:0]  t [CHK_W+1];

  modn_step #(.MOD(MOD), .W(CHK_W)) u_step (
    .r      (r_q),
    .b      (sh_q[SH_W-1]),
    .r_next (t[0])
  );

  for (genvar k = 0; k < CHK_W; k++) begin : g_chain
    modn_step #(.MOD(MOD), .W(CHK_W)) u_chain (
      .r      (t[k]),
      .b      (1'b0),
      .r_next (t[k+1])
    );
  end

  // Modulo arithmetic in CHK_W bits is exact here because the result is < MOD.
  assign chk_val = (t[CHK_W] == '0) ? '0 : (MOD_LO - t[CHK_W]);

  assign bus.in_ready = !rst && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_CHK) && (cnt_q == CHK_LAST)));
  assign accept  = bus.in_valid && bus.in_ready;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    sh_d    = sh_q;
    valid_d = valid_q;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    chk_d   = chk_q;

    case (state_q)
      ST_IDLE: ;
      ST_DATA: begin
        r_d   = t[0];
        sh_d  = sh_q << 1;
        cnt_d = cnt_inc;
        if (cnt_q == DATA_LAST) begin
          state_d = ST_CHK;
          cnt_d   = '0;
          r_d     = '0;
          sh_d    = SH_W'(chk_val) << CPAD;
          chk_d   = 1'b1;
          eof_d   = (CHK_LAST == '0);
        end
      end
      ST_CHK: begin
        sh_d  = sh_q << 1;
        cnt_d = cnt_inc;
        eof_d = (cnt_inc == CHK_LAST);
        if (cnt_q == CHK_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sh_d    = '0;
          valid_d = 1'b0;
          chk_d   = 1'b0;
          eof_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        r_d     = '0;
        sh_d    = '0;
        valid_d = 1'b0;
        chk_d   = 1'b0;
      end
    endcase

    // An accept on the last check bit chains straight into the next frame.
    if (accept) begin
      state_d = ST_DATA;
      cnt_d   = '0;
      r_d     = '0;
      sh_d    = SH_W'(bus.in_data) << DPAD;
      valid_d = 1'b1;
      sof_d   = 1'b1;
      eof_d   = 1'b0;
      chk_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      chk_q   <= chk_d;
    end
  end

  assign bus.ser_out   = sh_q[SH_W-1];
  assign bus.ser_valid = valid_q;
  assign bus.ser_sof   = sof_q;
  assign bus.ser_eof   = eof_q;
  assign bus.ser_chk   = chk_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_modn_check_framer.sv
// Directed and randomized checks of modn_check_framer for several moduli.
module tb_modn_check_framer;
  import modn_pkg::*;

  localparam int NRND = 2000;
  localparam int RMODS [5] = '{3, 5, 7, 10, 13};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   total    = 0;
  int   bad      = 0;
  int   seen_tot = 0;
  logic rnd_en   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed DUTs ----------------
  modn_check_framer_if #(.DATA_W(8)) if5 ();
  modn_check_framer_if #(.DATA_W(4)) if7 ();
  modn_check_framer_if #(.DATA_W(4)) if8 ();
  state_t st5, st7, st8;

  modn_check_framer #(.MOD(5), .DATA_W(8)) u5 (.clk(clk), .rst(rst), .bus(if5), .dbg_state(st5));
  modn_check_framer #(.MOD(7), .DATA_W(4)) u7 (.clk(clk), .rst(rst), .bus(if7), .dbg_state(st7));
  modn_check_framer #(.MOD(8), .DATA_W(4)) u8 (.clk(clk), .rst(rst), .bus(if8), .dbg_state(st8));

  // ---------------- random DUTs with scoreboard ----------------
  for (genvar g = 0; g < 5; g++) begin : g_rnd
    localparam int M  = RMODS[g];
    localparam int CW = $clog2(M);

    modn_check_framer_if #(.DATA_W(8)) rif ();
    state_t st;
    modn_check_framer #(.MOD(M), .DATA_W(8)) u_dut (.clk(clk), .rst(rst), .bus(rif), .dbg_state(st));

    logic [7:0]      exp_q [$];
    int              sent     = 0;
    logic            acc_pend = 1'b0;
    longint unsigned frame    = 0;
    int              len      = 0;

    // driver: new payload only after acceptance, random idle gaps
    always @(negedge clk) begin
      if (!rnd_en) begin
        rif.in_valid = 1'b0;
        rif.in_data  = '0;
        acc_pend     = 1'b0;
      end else begin
        if (acc_pend || !rif.in_valid) begin
          acc_pend = 1'b0;
          if (sent < NRND) begin
            rif.in_data  = 8'($urandom_range(0, 255));
            rif.in_valid = ($urandom_range(0, 3) != 0);
          end else begin
            rif.in_valid = 1'b0;
          end
        end
        if (rif.in_valid && rif.in_ready) begin
          exp_q.push_back(rif.in_data);
          sent++;
          acc_pend = 1'b1;
        end
      end
    end

    // monitor: serial mod-M checker restarted at every sof
    always @(negedge clk) begin
      if (rif.ser_valid) begin
        longint unsigned base;
        longint unsigned exp_frame;
        logic [7:0]      d;
        if (rif.ser_sof) begin
          frame = 0;
          len   = 0;
        end
        frame = (frame << 1) | longint'(rif.ser_out);
        len++;
        chk($sformatf("rnd_chkflag_m%0d", M), rif.ser_chk, (len > 8));
        if (rif.ser_eof) begin
          chk($sformatf("rnd_len_m%0d", M), len, 8 + CW);
          chk($sformatf("rnd_div_m%0d", M), frame % M, 0);
          chk($sformatf("rnd_q_m%0d", M), (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            d         = exp_q.pop_front();
            base      = longint'(d) << CW;
            exp_frame = base + ((M - (base % M)) % M);
            chk($sformatf("rnd_frame_m%0d", M), frame, exp_frame);
          end
          seen_tot++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready5(input string tag);
    int n = 0;
    while (!if5.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_timeout"}, (n < 64), 1);
  endtask

  task automatic frame5(input logic [7:0] d, output logic [10:0] bits, output logic [10:0] sof,
                        output logic [10:0] eof, output logic [10:0] ck, output logic [10:0] vld);
    if5.in_data  = d;
    if5.in_valid = 1'b1;
    wait_ready5("f5");
    @(negedge clk);
    if5.in_valid = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      bits[i] = if5.ser_out;
      sof[i]  = if5.ser_sof;
      eof[i]  = if5.ser_eof;
      ck[i]   = if5.ser_chk;
      vld[i]  = if5.ser_valid;
      @(negedge clk);
    end
  endtask

  task automatic frame4(input bit sel8, input logic [3:0] d, output logic [6:0] bits,
                        output logic [6:0] vld);
    int n = 0;
    if (sel8) begin
      if8.in_data = d; if8.in_valid = 1'b1;
    end else begin
      if7.in_data = d; if7.in_valid = 1'b1;
    end
    while (!(sel8 ? if8.in_ready : if7.in_ready) && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("f4_ready_timeout", (n < 64), 1);
    @(negedge clk);
    if7.in_valid = 1'b0;
    if8.in_valid = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      bits[i] = sel8 ? if8.ser_out : if7.ser_out;
      vld[i]  = sel8 ? if8.ser_valid : if7.ser_valid;
      @(negedge clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [10:0] b, s, e, c, v;
    logic [21:0] bb, vv, rr;
    logic [6:0]  b4, v4;
    int          n;
    int          stray;

    if5.in_valid = 1'b0; if5.in_data = '0;
    if7.in_valid = 1'b0; if7.in_data = '0;
    if8.in_valid = 1'b0; if8.in_data = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", if5.in_ready, 0);
    chk("rst_ser_valid", if5.ser_valid, 0);
    chk("rst_ser_flags", {if5.ser_out, if5.ser_sof, if5.ser_eof, if5.ser_chk}, 0);
    chk("rst_state", st5, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", if5.in_ready, 1);
    chk("idle_ser_valid", if5.ser_valid, 0);

    frame5(8'h0D, b, s, e, c, v);
    chk("m5_0d_bits", b, 11'b00001101001);
    chk("m5_0d_sof", s, 11'b10000000000);
    chk("m5_0d_eof", e, 11'b00000000001);
    chk("m5_0d_chk", c, 11'b00000000111);
    chk("m5_0d_valid", v, 11'h7FF);
    chk("m5_0d_after_valid", if5.ser_valid, 0);

    frame5(8'h00, b, s, e, c, v);
    chk("m5_00_bits", b, 11'b00000000000);
    frame5(8'hFF, b, s, e, c, v);
    chk("m5_ff_bits", b, 11'b11111111000);
    frame5(8'h01, b, s, e, c, v);
    chk("m5_01_bits", b, 11'b00000001010);

    frame4(1'b0, 4'hA, b4, v4);
    chk("m7_a_bits", b4, 7'b1010100);
    chk("m7_a_valid", v4, 7'h7F);
    frame4(1'b1, 4'hA, b4, v4);
    chk("m8_a_bits", b4, 7'b1010000);
    chk("m8_a_valid", v4, 7'h7F);

    // back-to-back with in_valid held high
    if5.in_data  = 8'h0D;
    if5.in_valid = 1'b1;
    wait_ready5("b2b");
    @(negedge clk);
    if5.in_data = 8'h01;
    for (int i = 21; i >= 0; i--) begin
      bb[i] = if5.ser_out;
      vv[i] = if5.ser_valid;
      rr[i] = if5.in_ready;
      if (i == 10) if5.in_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_bits", bb, {11'b00001101001, 11'b00000001010});
    chk("b2b_valid", vv, 22'h3FFFFF);
    chk("b2b_ready", rr, (22'd1 << 11) | 22'd1);
    chk("b2b_after_valid", if5.ser_valid, 0);

    // reset on the 4th data bit
    if5.in_data  = 8'h0D;
    if5.in_valid = 1'b1;
    wait_ready5("mid");
    @(negedge clk);
    if5.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_valid_before", if5.ser_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_abort_valid", if5.ser_valid, 0);
    chk("mid_rst_ready", if5.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_post_ready", if5.in_ready, 1);
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if5.ser_valid) stray++;
    end
    chk("mid_no_partial", stray, 0);
    frame5(8'h01, b, s, e, c, v);
    chk("mid_next_bits", b, 11'b00000001010);
    chk("mid_next_valid", v, 11'h7FF);

    // randomized phase
    rnd_en = 1'b1;
    n = 0;
    while (seen_tot < 5 * NRND && n < 60000) begin
      @(negedge clk);
      n++;
    end
    chk("rnd_frames_seen", seen_tot, 5 * NRND);
    rnd_en = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
